// File: rtl/rf_scoreboard.sv
// rf_scoreboard: integer register file with one write port, two combinational
// read ports, optional write-to-read forwarding and a per-register busy
// scoreboard used by decode to detect RAW hazards on in-flight producers.
module rf_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     busy_cnt
);

    // Register storage. Index 0 is a constant zero and never holds state.
    logic [XLEN-1:0] w_regs [NREG];
    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0] r_q;

            // Capture writeback data when this register is addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    r_q <= wr_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    // Scoreboard state and its registered population count.
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [AW:0]     r_busy_cnt;
    logic [AW:0]     w_cnt_next;

    // Next busy vector: clear on writeback, then flush, then set on reserve,
    // so a reserve always wins over a clear or a flush in the same cycle.
    always_comb begin
        w_busy_next = r_busy;
        if (wr_en) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (flush) begin
            w_busy_next = '0;
        end
        if (rsv_en) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Popcount of the next busy vector so busy_cnt tracks r_busy exactly.
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[i]};
        end
    end

    // Busy vector and count update together on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_cnt_next;
        end
    end

    // Forwarding applies only to a real write (index 0 excluded) that
    // targets the same register being read.
    logic w_fwd1;
    logic w_fwd2;
    assign w_fwd1 = (BYPASS != 0) && wr_en && (wr_addr != '0) && (wr_addr == rd_addr1);
    assign w_fwd2 = (BYPASS != 0) && wr_en && (wr_addr != '0) && (wr_addr == rd_addr2);

    // Read ports: forced to zero while reset is held so forwarded data
    // cannot leak out during reset.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        busy1    = 1'b0;
        busy2    = 1'b0;
        if (!rst) begin
            rd_data1 = w_fwd1 ? wr_data : w_regs[rd_addr1];
            rd_data2 = w_fwd2 ? wr_data : w_regs[rd_addr2];
            busy1    = r_busy[rd_addr1] && !w_fwd1;
            busy2    = r_busy[rd_addr2] && !w_fwd2;
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: two instances (forwarding on and off) share one
// stimulus stream and are compared against a behavioural register/busy model.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;

    logic [XLEN-1:0] rd_data1_b, rd_data2_b, rd_data1_n, rd_data2_n;
    logic            busy1_b, busy2_b, busy1_n, busy2_n;
    logic [AW:0]     busy_cnt_b, busy_cnt_n;

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(busy1_b), .busy2(busy2_b), .busy_cnt(busy_cnt_b)
    );

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_n), .rd_data2(rd_data2_n),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(busy1_n), .busy2(busy2_n), .busy_cnt(busy_cnt_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values and the set of busy registers.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    function automatic void model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Apply the inputs present at a clock edge to the model.
    function automatic void model_edge();
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        for (int r = 1; r < NREG; r++) begin
            if (wr_en && int'(wr_addr) == r) m_busy[r] = 1'b0;
            if (flush) m_busy[r] = 1'b0;
            if (rsv_en && int'(rsv_addr) == r) m_busy[r] = 1'b1;
        end
    endfunction

    function automatic logic fwd(input int ra, input bit bp);
        return bp && wr_en && wr_addr != 0 && int'(wr_addr) == ra;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int ra, input bit bp);
        if (rst) return '0;
        if (fwd(ra, bp)) return wr_data;
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input int ra, input bit bp);
        if (rst) return 1'b0;
        if (fwd(ra, bp)) return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_comb();
        chk("rd1_byp",   rd_data1_b, exp_rd(int'(rd_addr1), 1'b1));
        chk("rd2_byp",   rd_data2_b, exp_rd(int'(rd_addr2), 1'b1));
        chk("rd1_nob",   rd_data1_n, exp_rd(int'(rd_addr1), 1'b0));
        chk("rd2_nob",   rd_data2_n, exp_rd(int'(rd_addr2), 1'b0));
        chk("busy1_byp", 32'(busy1_b), 32'(exp_busy(int'(rd_addr1), 1'b1)));
        chk("busy2_byp", 32'(busy2_b), 32'(exp_busy(int'(rd_addr2), 1'b1)));
        chk("busy1_nob", 32'(busy1_n), 32'(exp_busy(int'(rd_addr1), 1'b0)));
        chk("busy2_nob", 32'(busy2_n), 32'(exp_busy(int'(rd_addr2), 1'b0)));
    endtask

    task automatic check_cnt();
        chk("cnt_byp", 32'(busy_cnt_b), 32'(model_count()));
        chk("cnt_nob", 32'(busy_cnt_n), 32'(model_count()));
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, clock,
    // then check the registered count just after the edge.
    task automatic step(input logic we, input int wa, input logic [XLEN-1:0] wd,
                        input int ra1, input int ra2,
                        input logic rv, input int rva, input logic fl);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        rd_addr1 = AW'(ra1);
        rd_addr2 = AW'(ra2);
        rsv_en   = rv;
        rsv_addr = AW'(rva);
        flush    = fl;
        #2;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_cnt();
        $display("step we=%0d wa=%0d wd=%h ra1=%0d ra2=%0d rsv=%0d@%0d fl=%0d cnt=%0d",
                 we, wa, wd, ra1, ra2, rv, rva, fl, busy_cnt_b);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr1 = 0; rd_addr2 = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_cnt();

        // Plain write then read; write to x0 is dropped.
        step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(1, 0, 32'h00001234, 3, 0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 3, 0, 0, 0);
        chk("x3_direct", rd_data2_b, 32'hDEADBEEF);

        // Same-cycle forwarding on port 2.
        step(1, 7, 32'hA5A5A5A5, 3, 7, 0, 0, 0);
        step(0, 0, 32'h0, 7, 7, 0, 0, 0);

        // Reserve then retire x10.
        step(0, 0, 32'h0, 0, 0, 1, 10, 0);
        step(0, 0, 32'h0, 10, 0, 0, 0, 0);
        step(1, 10, 32'h55, 10, 10, 0, 0, 0);
        chk("x10_cnt_after", 32'(busy_cnt_b), 32'd0);

        // Reserve and write to the same register.
        step(1, 12, 32'hC0FFEE12, 12, 0, 1, 12, 0);
        step(0, 0, 32'h0, 12, 12, 0, 0, 0);
        chk("x12_cnt", 32'(busy_cnt_b), 32'd1);

        // Flush together with a reserve keeps only the reserved register.
        step(0, 0, 32'h0, 4, 5, 1, 4, 0);
        step(0, 0, 32'h0, 5, 6, 1, 5, 0);
        step(0, 0, 32'h0, 6, 9, 1, 6, 0);
        step(0, 0, 32'h0, 4, 9, 1, 9, 1);
        chk("flush_rsv_cnt", 32'(busy_cnt_b), 32'd1);
        step(0, 0, 32'h0, 0, 9, 1, 0, 0);
        chk("rsv_x0_cnt", 32'(busy_cnt_b), 32'd1);

        // Fill the scoreboard, re-reserve, then flush.
        for (int r = 1; r < NREG; r++) step(0, 0, 32'h0, r, r - 1, 1, r, 0);
        chk("full_cnt", 32'(busy_cnt_b), 32'd31);
        step(0, 0, 32'h0, 1, 31, 1, 1, 0);
        chk("rersv_cnt", 32'(busy_cnt_b), 32'd31);
        step(0, 0, 32'h0, 1, 2, 0, 0, 1);
        chk("flush_cnt", 32'(busy_cnt_b), 32'd0);

        // Asynchronous reset in the middle of a cycle carrying a write and reserve.
        step(1, 5, 32'h5555AAAA, 5, 3, 1, 8, 0);
        wr_en = 1; wr_addr = 5; wr_data = 32'h12345678;
        rd_addr1 = 5; rd_addr2 = 8; rsv_en = 1; rsv_addr = 9; flush = 0;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_comb();
        check_cnt();
        @(posedge clk);
        #1;
        check_comb();
        check_cnt();
        rst = 1'b0;
        step(0, 0, 32'h0, 5, 3, 0, 0, 0);
        chk("x5_after_rst", rd_data1_b, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step(logic'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)), $urandom(),
                 int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                 logic'($urandom_range(0, 9) < 4), int'($urandom_range(0, NREG - 1)),
                 logic'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
